// File: rtl/run_sequencer_pkg.sv
// Shared types and default widths for the run sequencer.
// Imported by the sequencer, its watchdog and its bus interface.
package run_seq_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int DEF_CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        FINISH
    } run_state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Host access port plus data-memory port of the run sequencer.
// The master side is the host/memory, the slave side the sequencer.
interface run_sequencer_if
    import run_seq_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          host_wr_en;
    logic          host_rd_en;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_dat_in;
    logic [DW-1:0] host_dat_out;
    logic          host_ack;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat_in;
    logic [DW-1:0] mem_dat_out;

    modport master (
        output host_wr_en,
        output host_rd_en,
        output host_addr,
        output host_dat_in,
        input  host_dat_out,
        input  host_ack,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_dat_in,
        output mem_dat_out
    );

    modport slave (
        input  host_wr_en,
        input  host_rd_en,
        input  host_addr,
        input  host_dat_in,
        output host_dat_out,
        output host_ack,
        output mem_wr_en,
        output mem_addr,
        output mem_dat_in,
        input  mem_dat_out
    );
endinterface

// File: rtl/run_sequencer_watchdog.sv
// Run-cycle counter with a fixed watchdog limit.
// expired is high during the last permitted run cycle.
module run_watchdog #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          expired
);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    // count run cycles; cleared when a new run is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);
endmodule

// File: rtl/run_sequencer.sv
// Sequences one core run: reset hold, run, watchdog, completion.
// Also arbitrates the data-memory port between host and core.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int CW         = DEF_CW,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    input  logic          core_mem_wr_en,
    input  logic [AW-1:0] core_mem_addr,
    input  logic [DW-1:0] core_mem_dat,
    run_sequencer_if.slave bus,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] CLR_LOAD = RW'(RST_CYCLES - 1);

    run_state_t    state_q;
    run_state_t    state_d;
    logic [RW-1:0] clr_q;
    logic          start;
    logic          in_run;
    logic          expired;
    logic          host_go;

    assign start   = (state_q == IDLE) && req;
    assign in_run  = (state_q == RUN);
    assign host_go = (state_q == IDLE) &&
                     (bus.host_wr_en || bus.host_rd_en);

    run_watchdog #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (start),
        .en      (in_run),
        .count   (cycle_count),
        .expired (expired)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = CLEAR;
            CLEAR:   if (clr_q == '0) state_d = RUN;
            RUN:     if (core_done || expired) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // core reset, busy and memory-port mux
    always_comb begin
        core_reset     = 1'b1;
        busy           = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = core_mem_addr;
        bus.mem_dat_in = core_mem_dat;
        unique case (state_q)
            IDLE: begin
                bus.mem_wr_en  = bus.host_wr_en;
                bus.mem_addr   = bus.host_addr;
                bus.mem_dat_in = bus.host_dat_in;
            end
            CLEAR: begin
                busy = 1'b1;
            end
            RUN: begin
                core_reset    = 1'b0;
                busy          = 1'b1;
                bus.mem_wr_en = core_mem_wr_en;
            end
            default: begin
            end
        endcase
    end

    // clear-phase length counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_q <= '0;
        end else if (start) begin
            clr_q <= CLR_LOAD;
        end else if (state_q == CLEAR && clr_q != '0) begin
            clr_q <= clr_q - 1'b1;
        end
    end

    // sticky completion flags; core_done beats the watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            timeout <= 1'b0;
        end else if (start) begin
            done    <= 1'b0;
            timeout <= 1'b0;
        end else if (in_run && (core_done || expired)) begin
            done    <= 1'b1;
            timeout <= ~core_done;
        end
    end

    // host acknowledge and registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.host_ack     <= 1'b0;
            bus.host_dat_out <= '0;
        end else begin
            bus.host_ack <= host_go;
            if (host_go && bus.host_rd_en && !bus.host_wr_en) begin
                bus.host_dat_out <= bus.mem_dat_out;
            end
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: host port, runs, watchdog, reset.
// Instance a uses the default watchdog, instance b a 16-cycle one.
module tb_run_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       core_done = 1'b0;
    logic       core_mem_wr_en = 1'b0;
    logic [7:0] core_mem_addr = '0;
    logic [7:0] core_mem_dat = '0;
    logic       host_wr_en = 1'b0;
    logic       host_rd_en = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_dat_in = '0;

    logic        core_reset_a, busy_a, done_a, timeout_a;
    logic        core_reset_b, busy_b, done_b, timeout_b;
    logic [15:0] cnt_a, cnt_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int n_cmp = 0;
    int n_bad = 0;

    run_sequencer_if #(.AW(8), .DW(8)) bus_a ();
    run_sequencer_if #(.AW(8), .DW(8)) bus_b ();

    always #5 clk = ~clk;

    assign bus_a.host_wr_en  = host_wr_en;
    assign bus_a.host_rd_en  = host_rd_en;
    assign bus_a.host_addr   = host_addr;
    assign bus_a.host_dat_in = host_dat_in;
    assign bus_a.mem_dat_out = mem_a[bus_a.mem_addr];
    assign bus_b.host_wr_en  = 1'b0;
    assign bus_b.host_rd_en  = 1'b0;
    assign bus_b.host_addr   = '0;
    assign bus_b.host_dat_in = '0;
    assign bus_b.mem_dat_out = mem_b[bus_b.mem_addr];

    always @(posedge clk) begin
        if (bus_a.mem_wr_en) mem_a[bus_a.mem_addr] <= bus_a.mem_dat_in;
        if (bus_b.mem_wr_en) mem_b[bus_b.mem_addr] <= bus_b.mem_dat_in;
    end

    run_sequencer dut_a (
        .clk            (clk),
        .reset          (reset),
        .req            (req_a),
        .core_done      (core_done),
        .core_mem_wr_en (core_mem_wr_en),
        .core_mem_addr  (core_mem_addr),
        .core_mem_dat   (core_mem_dat),
        .bus            (bus_a),
        .core_reset     (core_reset_a),
        .busy           (busy_a),
        .done           (done_a),
        .timeout        (timeout_a),
        .cycle_count    (cnt_a)
    );

    run_sequencer #(.TIMEOUT(16)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .req            (req_b),
        .core_done      (core_done),
        .core_mem_wr_en (core_mem_wr_en),
        .core_mem_addr  (core_mem_addr),
        .core_mem_dat   (core_mem_dat),
        .bus            (bus_b),
        .core_reset     (core_reset_b),
        .busy           (busy_b),
        .done           (done_b),
        .timeout        (timeout_b),
        .cycle_count    (cnt_b)
    );

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({core_reset_a, busy_a, done_a, timeout_a} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 1000",
                     {core_reset_a, busy_a, done_a, timeout_a});
        end
        n_cmp++;
        if (cnt_a !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_count got %0d want 0", cnt_a);
        end
        n_cmp++;
        if ({bus_a.host_ack, bus_a.host_dat_out} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_host got %h want 000",
                     {bus_a.host_ack, bus_a.host_dat_out});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_host();
        host_wr_en = 1'b1; host_addr = 8'h10; host_dat_in = 8'hA5;
        #1;
        n_cmp++;
        if ({bus_a.mem_wr_en, bus_a.mem_addr} !== 9'h110) begin
            n_bad++;
            $display("FAIL host_wr_mux got %h want 110",
                     {bus_a.mem_wr_en, bus_a.mem_addr});
        end
        @(negedge clk);
        host_wr_en = 1'b0;
        n_cmp++;
        if (bus_a.host_ack !== 1'b1 || core_reset_a !== 1'b1) begin
            n_bad++;
            $display("FAIL host_wr_ack got %b%b want 11",
                     bus_a.host_ack, core_reset_a);
        end
        n_cmp++;
        if (mem_a[8'h10] !== 8'hA5) begin
            n_bad++;
            $display("FAIL host_wr_mem got %h want a5", mem_a[8'h10]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_a.host_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL host_ack_pulse got %b want 0", bus_a.host_ack);
        end
        host_rd_en = 1'b1;
        @(negedge clk);
        host_rd_en = 1'b0;
        n_cmp++;
        if (bus_a.host_ack !== 1'b1 || bus_a.host_dat_out !== 8'hA5) begin
            n_bad++;
            $display("FAIL host_rd got ack=%b dat=%h want ack=1 dat=a5",
                     bus_a.host_ack, bus_a.host_dat_out);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_a.host_ack !== 1'b0 || core_reset_a !== 1'b1) begin
            n_bad++;
            $display("FAIL host_rd_end got %b%b want 01",
                     bus_a.host_ack, core_reset_a);
        end
    endtask

    task automatic test_run_done();
        int hi;
        int bad;
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (core_reset_a === 1'b1 && busy_a === 1'b1) begin
                hi++;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (hi !== 2) begin
            n_bad++;
            $display("FAIL clear_len got %0d want 2", hi);
        end
        bad = 0;
        for (int i = 0; i < 49; i++) begin
            if (core_reset_a !== 1'b0 || busy_a !== 1'b1) bad++;
            if (cnt_a !== 16'(i)) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL run_phase got %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if (cnt_a !== 16'd49) begin
            n_bad++;
            $display("FAIL run_count49 got %0d want 49", cnt_a);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        n_cmp++;
        if ({done_a, timeout_a, busy_a, core_reset_a} !== 4'b1001) begin
            n_bad++;
            $display("FAIL finish_flags got %b want 1001",
                     {done_a, timeout_a, busy_a, core_reset_a});
        end
        n_cmp++;
        if (cnt_a !== 16'd50) begin
            n_bad++;
            $display("FAIL finish_count got %0d want 50", cnt_a);
        end
        @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL done_sticky got %b%b want 10", done_a, busy_a);
        end
    endtask

    task automatic test_conflict();
        req_a = 1'b1;
        host_wr_en = 1'b1; host_addr = 8'h30; host_dat_in = 8'h77;
        @(negedge clk);
        req_a = 1'b0;
        host_wr_en = 1'b0;
        n_cmp++;
        if (bus_a.host_ack !== 1'b1 || busy_a !== 1'b1 ||
            mem_a[8'h30] !== 8'h77 || done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL req_host got ack=%b busy=%b m=%h d=%b want 1 1 77 0",
                     bus_a.host_ack, busy_a, mem_a[8'h30], done_a);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (core_reset_a !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_run got %b want 0", core_reset_a);
        end
        core_mem_wr_en = 1'b1; core_mem_addr = 8'h20;
        core_mem_dat = 8'h3C;
        host_wr_en = 1'b1; host_addr = 8'h20; host_dat_in = 8'hFF;
        #1;
        n_cmp++;
        if ({bus_a.mem_addr, bus_a.mem_dat_in} !== 16'h203C) begin
            n_bad++;
            $display("FAIL conflict_mux got %h want 203c",
                     {bus_a.mem_addr, bus_a.mem_dat_in});
        end
        @(negedge clk);
        core_mem_wr_en = 1'b0;
        host_wr_en = 1'b0;
        n_cmp++;
        if (mem_a[8'h20] !== 8'h3C || bus_a.host_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_mem got m=%h ack=%b want 3c 0",
                     mem_a[8'h20], bus_a.host_ack);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        repeat (15) @(negedge clk);
        n_cmp++;
        if (cnt_b !== 16'd15 || busy_b !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_pre got cnt=%0d busy=%b want 15 1",
                     cnt_b, busy_b);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_b, timeout_b, busy_b} !== 3'b110 || cnt_b !== 16'd16) begin
            n_bad++;
            $display("FAIL wd_fire got %b cnt=%0d want 110 16",
                     {done_b, timeout_b, busy_b}, cnt_b);
        end
        @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        n_cmp++;
        if ({done_b, timeout_b} !== 2'b00 || cnt_b !== 16'd0) begin
            n_bad++;
            $display("FAIL wd_restart got %b cnt=%0d want 00 0",
                     {done_b, timeout_b}, cnt_b);
        end
    endtask

    task automatic test_done_on_limit();
        repeat (2) @(negedge clk);
        repeat (15) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        n_cmp++;
        if ({done_b, timeout_b} !== 2'b10 || cnt_b !== 16'd16) begin
            n_bad++;
            $display("FAIL tie_break got %b cnt=%0d want 10 16",
                     {done_b, timeout_b}, cnt_b);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({core_reset_a, busy_a, done_a, timeout_a} !== 4'b1000) begin
            n_bad++;
            $display("FAIL async_flags got %b want 1000",
                     {core_reset_a, busy_a, done_a, timeout_a});
        end
        n_cmp++;
        if (cnt_a !== 16'd0) begin
            n_bad++;
            $display("FAIL async_count got %0d want 0", cnt_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (core_reset_a !== 1'b0 || cnt_a !== 16'd0) begin
            n_bad++;
            $display("FAIL rerun_start got %b cnt=%0d want 0 0",
                     core_reset_a, cnt_a);
        end
        repeat (2) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        n_cmp++;
        if (done_a !== 1'b1 || timeout_a !== 1'b0 || cnt_a !== 16'd3) begin
            n_bad++;
            $display("FAIL rerun_end got %b%b cnt=%0d want 10 3",
                     done_a, timeout_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_host();
        test_run_done();
        test_conflict();
        test_timeout();
        test_done_on_limit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Sequences one program run of the single-cycle core. It holds the core in reset, releases it on a start request, and watches for program completion or a watchdog timeout.
- It also arbitrates the single data-memory port. The host (bench/loader) owns the port when idle; the core owns it while running.
- It sits between the external req/done handshake and the core's reset, memory-write and done signals.

Parameters:
- AW, 8, data-memory address width
- DW, 8, data-memory data width
- CW, 16, cycle counter width
- RST_CYCLES, 2, cycles core_reset is held after a start is accepted (min 1)
- TIMEOUT, 4096, RUN-state cycles before forced abort (must be < 2^CW)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  1  start request, level-sampled in IDLE
- core_done  input  1  core finished (PC reached end address)
- core_mem_wr_en  input  1  core store enable
- core_mem_addr  input  AW  core memory address
- core_mem_dat  input  DW  core store data
- host_wr_en  input  1  host write request
- host_rd_en  input  1  host read request
- host_addr  input  AW  host address
- host_dat_in  input  DW  host write data
- mem_dat_out  input  DW  read data from data memory (combinational read)
- mem_wr_en  output  1  muxed write enable to data memory
- mem_addr  output  AW  muxed address to data memory
- mem_dat_in  output  DW  muxed write data to data memory
- host_dat_out  output  DW  registered host read data
- host_ack  output  1  one-cycle acknowledge of a host access
- core_reset  output  1  reset to core (PC, flags)
- busy  output  1  high in CLEAR and RUN
- done  output  1  run complete; sticky until next start
- timeout  output  1  run aborted by watchdog; sticky until next start
- cycle_count  output  CW  RUN cycles of current/last run

Behaviour:
- Reset values: state IDLE, core_reset=1, busy=0, done=0, timeout=0, cycle_count=0, host_ack=0, host_dat_out=0, clear-phase counter=0.
- IDLE: core_reset=1.
  - Host owns memory: mem_addr=host_addr, mem_dat_in=host_dat_in, mem_wr_en=host_wr_en.
  - req=1 moves to CLEAR next edge; clears done, timeout and cycle_count on that edge; loads the clear counter with RST_CYCLES-1.
- CLEAR: core_reset=1, mem_wr_en=0, mem_addr=core_mem_addr.
  - Counter decrements each cycle; at 0 moves to RUN.
  - CLEAR lasts exactly RST_CYCLES cycles.
- RUN: core_reset=0; core owns memory (mem_* = core_mem_*).
  - cycle_count increments every cycle.
  - core_done=1 moves to FINISH and sets done.
  - Otherwise, cycle_count==TIMEOUT-1 moves to FINISH and sets done and timeout.
  - If both happen in the same cycle, core_done wins and timeout stays 0.
  - Final cycle_count includes the terminating cycle.
- FINISH: one cycle; core_reset=1, mem_wr_en=0; then IDLE. done/timeout remain high until the next accepted req.
- Host access outside IDLE is ignored: no ack, no write, host_dat_out holds.
- Host access in IDLE:
  - host_ack=1 on the next cycle for a single cycle.
  - A read captures mem_dat_out into host_dat_out on the same edge.
  - rd and wr together: the write occurs, ack is given, host_dat_out is not updated.
- req and a host access in the same IDLE cycle: the host access completes (write lands, ack next cycle) and the start is also accepted.
- req while busy or in FINISH: ignored. req held high through FINISH restarts the run from IDLE the cycle after.
- Reset mid-run: immediate return to IDLE, core_reset=1; no done or timeout is asserted.
- cycle_count never wraps, because the watchdog bounds it.

Decomposition:
- Shared package run_seq_pkg holds:
  - typedef enum logic[1:0] {IDLE, CLEAR, RUN, FINISH} run_state_t
  - default widths AW/DW/CW as localparams for top-level use
- Sub-module run_watchdog:
  - cycle counter with clear/enable inputs, TIMEOUT compare and expired output
  - instantiated once
- The memory mux and host port stay inline.

Test Plan:
- Reset, then host writes addr 0x10=0xA5, then reads 0x10 → host_ack one cycle after each; host_dat_out=0xA5; core_reset=1 throughout.
- req pulse, core_done raised after 50 RUN cycles → core_reset high exactly 2 cycles then low; busy high in CLEAR/RUN; done=1; cycle_count=50; timeout=0.
- RUN with core_mem_wr_en=1, addr 0x20, data 0x3C, and host_wr_en=1 to 0x20 with data 0xFF at the same time → memory holds 0x3C; host_ack stays 0.
- core_done never asserted, TIMEOUT=16 → FINISH after 16 RUN cycles; done=1, timeout=1, cycle_count=16. A new req clears both.
- core_done on the exact watchdog cycle → timeout=0, done=1.
- Async reset asserted mid-RUN between clock edges → core_reset=1 and busy=0 immediately; done=0; next req starts a clean run with cycle_count cleared.
